// File: rtl/d_branch_predict_cmp.sv
// Decode-stage branch resolution with a 2-bit saturating-counter BHT shared with the fetch lookup.
// Optional resolved/mispredicted branch counters are built when BRANCH_STATS_EN is defined.
module d_branch_predict_cmp #(
   parameter int         WIDTH     = 32,
   parameter int         BHT_DEPTH = 16,
   parameter logic [1:0] CTR_INIT  = 2'b01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             f_valid,
   input  logic [31:0]      f_pc,
   output logic             f_pred_taken,
   input  logic             d_valid,
   input  logic             d_branch,
   input  logic             d_stall,
   input  logic [31:0]      d_pc,
   input  logic [2:0]       d_cmp_op,
   input  logic             d_pred_taken,
   input  logic [WIDTH-1:0] rs_value,
   input  logic [WIDTH-1:0] rt_value,
   output logic             pc_src,
   output logic             mispredict
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]      branch_count,
   output logic [31:0]      mispredict_count
`endif
);

   localparam int IDX = $clog2(BHT_DEPTH);

   logic [1:0]     bht_q [BHT_DEPTH];
   logic [IDX-1:0] f_idx;
   logic [IDX-1:0] d_idx;
   logic [1:0]     d_ctr;
   logic [1:0]     ctr_d;
   logic           resolve;
   logic           update;
   logic           cond;
   logic           rs_neg;
   logic           rs_zero;

   assign f_idx   = f_pc[IDX+1:2];
   assign d_idx   = d_pc[IDX+1:2];
   assign resolve = d_valid & d_branch;
   assign update  = resolve & ~d_stall & ~reset;

   assign rs_neg  = rs_value[WIDTH-1];
   assign rs_zero = (rs_value == '0);

   always_comb begin
      cond = 1'b0;
      case (d_cmp_op)
         3'b000:  cond = (rs_value == rt_value);
         3'b001:  cond = (rs_value != rt_value);
         3'b010:  cond = (rs_value < rt_value);
         3'b011:  cond = ($signed(rs_value) < $signed(rt_value));
         3'b100:  cond = ~rs_neg;
         3'b101:  cond = rs_neg;
         3'b110:  cond = ~rs_neg & ~rs_zero;
         3'b111:  cond = rs_neg | rs_zero;
         default: cond = 1'b0;
      endcase
   end

   assign pc_src       = resolve & cond;
   assign mispredict   = resolve & (pc_src != d_pred_taken);
   // Combinational read of the registered array: a same-cycle F lookup sees the pre-update value.
   assign f_pred_taken = f_valid & bht_q[f_idx][1];

   assign d_ctr = bht_q[d_idx];

   always_comb begin
      ctr_d = d_ctr;
      if (pc_src) begin
         if (d_ctr != 2'b11) ctr_d = d_ctr + 2'd1;
      end else begin
         if (d_ctr != 2'b00) ctr_d = d_ctr - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
      end else if (update) begin
         bht_q[d_idx] <= ctr_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispredict_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else if (update) begin
         branch_cnt_q <= branch_cnt_q + 32'd1;
         if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
   end

   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispredict_cnt_q;
`endif

endmodule

// File: doc/d_branch_predict_cmp.md
# d_branch_predict_cmp

Decode-stage branch resolution unit with a parametrised operand width and an integrated branch history table (BHT) of 2-bit saturating counters. It resolves the branch condition in D from forwarded register values, flags a misprediction against the prediction carried down from F, and trains the BHT on every resolved branch. It also serves the fetch-stage prediction lookup. It sits between the register-forwarding muxes in D and the PC-select logic in F.

## Interface
Parameters:
- `WIDTH`, 32, operand width of `rs_value`/`rt_value`.
- `BHT_DEPTH`, 16, number of counters; must be a power of two ≥ 2; index bits `IDX = $clog2(BHT_DEPTH)`.
- `CTR_INIT`, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `f_valid`  in  1  fetch lookup valid.
- `f_pc`  in  32  fetch PC.
- `f_pred_taken`  out  1  predicted taken for `f_pc`.
- `d_valid`  in  1  D-stage instruction valid.
- `d_branch`  in  1  D-stage instruction is a conditional branch.
- `d_stall`  in  1  D stage held this cycle.
- `d_pc`  in  32  PC of the D-stage instruction.
- `d_cmp_op`  in  3  condition select.
- `d_pred_taken`  in  1  prediction made for this instruction in F.
- `rs_value`  in  WIDTH  forwarded rs operand.
- `rt_value`  in  WIDTH  forwarded rt operand.
- `pc_src`  out  1  branch resolved taken.
- `mispredict`  out  1  resolved outcome ≠ `d_pred_taken`.
- `branch_count`  out  32  resolved-branch counter (only with `BRANCH_STATS_EN`).
- `mispredict_count`  out  32  misprediction counter (only with `BRANCH_STATS_EN`).

## Operation
- `resolve = d_valid & d_branch`. `update = resolve & ~d_stall & ~reset`.
- `d_cmp_op` encodings:
  - 000 beq: rs == rt.
  - 001 bne: rs != rt.
  - 010 bltu: unsigned rs < rt.
  - 011 blt: signed rs < rt.
  - 100 bgez: rs[WIDTH-1] == 0.
  - 101 bltz: rs[WIDTH-1] == 1.
  - 110 bgtz: rs signed > 0.
  - 111 blez: rs signed ≤ 0.
- `pc_src` = condition when `resolve`, else 0. It has no latch path; every input combination drives a value.
- `mispredict` = `resolve & (pc_src != d_pred_taken)`. It is asserted even while stalled; consumers qualify it with `~d_stall`.
- Index: F uses `f_pc[IDX+1:2]`; D uses `d_pc[IDX+1:2]`.
- `f_pred_taken` = `f_valid & bht[f_idx][1]`.
- Training on `update`:
  - Taken: counter +1, saturating at 3.
  - Not taken: counter −1, saturating at 0.
  - Only the indexed entry changes.

## Timing
- `pc_src`, `mispredict`, `f_pred_taken`: combinational, zero latency.
- A BHT write is visible to an F lookup from the cycle after the edge. When F and D hit the same index in the same cycle, F reads the pre-update value.
- While `d_stall` is high the counter is not updated, so a stalled branch trains exactly once, on the cycle it leaves D.
- Reset values:
  - All counters = `CTR_INIT`.
  - Stats counters = 0.
  - `pc_src`, `mispredict`, `f_pred_taken` follow their inputs. With `CTR_INIT`[1]=0, `f_pred_taken` = 0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. An update pending on that edge is discarded.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments on every `update`.
  - `mispredict_count` increments on every `update & mispredict`.
  - Both wrap at 2^32 − 1 → 0.
- `BRANCH_STATS_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset then lookup: `f_valid`=1, `f_pc`=0x3000 → `f_pred_taken`=0; rs=5, rt=5, op 000, `resolve` → `pc_src`=1.
- Signed vs unsigned compare, WIDTH=32: rs=0xFFFFFFFF, rt=1.
  - op 010 → `pc_src`=0.
  - op 011 → `pc_src`=1, and with `d_pred_taken`=0 → `mispredict`=1.
- Saturation, all at `d_pc`=0x3004:
  - Three taken updates → counter 3, `f_pred_taken`=1 for `f_pc`=0x3004.
  - Fourth taken update → counter stays 3.
  - Two not-taken updates → counter 1, `f_pred_taken`=0.
- Stall: a taken branch held with `d_stall`=1 for 3 cycles, then released → counter changes by exactly +1 and `branch_count` +1.
- Same-cycle hazard: F and D both at index 1, counter 1, taken update → `f_pred_taken`=0 that cycle, 1 the next cycle.
- Async reset mid-run: counter 3, `reset` pulsed between clock edges → `f_pred_taken`=0 immediately, stats read 0.
